// File: rtl/mem_db_ctrl_pkg.sv
// Shared constants for the double-buffered memory controller.
// Holds the default word width and frame depth used by mem_db_ctrl and
// its output FIFO, so every user of the double-buffer RAM agrees on them.
package mem_db_ctrl_pkg;

    // Default word width in bits.
    localparam int MEM_DB_DATA_BIT = 64;

    // Default words per frame. This is also the depth of each RAM bank.
    localparam int MEM_DB_DEPTH    = 1024;

endpackage

// File: rtl/mem_db_ctrl_skid2.sv
// mem_skid2: two-entry output FIFO for mem_db_ctrl.
// It captures RAM read data one cycle after each read and presents the
// oldest word to the consumer.
// Ports:
//   clk, rst_n  clock; synchronous active-low reset (clears to empty)
//   push        load push_data into the tail this cycle
//   push_data   word to load
//   pop         consumer took the head this cycle
//   valid       FIFO non-empty
//   head        oldest stored word
//   count       occupancy, 0..2
module mem_skid2
    import mem_db_ctrl_pkg::*;
#(
    parameter int DATA_BIT = MEM_DB_DATA_BIT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic [DATA_BIT-1:0] push_data,
    input  logic                pop,
    output logic                valid,
    output logic [DATA_BIT-1:0] head,
    output logic [1:0]          count
);

    logic [DATA_BIT-1:0] slot0;
    logic [DATA_BIT-1:0] slot1;
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          cnt;
    logic                do_push;
    logic                do_pop;

    // The controller's credit check already prevents overflow.
    // These guards keep the FIFO self-consistent even if a caller misbehaves.
    assign do_pop  = pop && (cnt != 2'd0);
    assign do_push = push && ((cnt != 2'd2) || do_pop);

    assign valid = (cnt != 2'd0);
    assign head  = rd_ptr ? slot1 : slot0;
    assign count = cnt;

    // Pointer and occupancy bookkeeping. A simultaneous push and pop
    // leaves the occupancy unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Data slots need no reset: a slot is only read while it is counted
    // as occupied.
    always_ff @(posedge clk) begin
        if (do_push) begin
            if (wr_ptr) begin
                slot1 <= push_data;
            end else begin
                slot0 <= push_data;
            end
        end
    end

endmodule

// File: rtl/mem_db_ctrl.sv
// mem_db_ctrl: ping-pong (double-buffer) controller.
// A producer fills one RAM bank with a frame while the consumer drains
// the previous frame from the other bank. Banks swap once both sides
// have finished their frame.
// Ports:
//   clk, rst_n                      clock; synchronous active-low reset
//   in_valid/in_ready/in_data       producer handshake and word
//   out_valid/out_ready/out_data    consumer handshake and word
//   mem_sw                          bank select (1: write bank0, read bank1)
//   mem_waddr/mem_wen/mem_wdata     RAM write port
//   mem_raddr/mem_ren               RAM read port
//   mem_rdata                       RAM read data, one cycle after mem_ren
//   swap                            pulses on the cycle a bank swap commits
module mem_db_ctrl
    import mem_db_ctrl_pkg::*;
#(
    parameter int DATA_BIT = MEM_DB_DATA_BIT,
    parameter int DEPTH    = MEM_DB_DEPTH,
    parameter int ADDR_BIT = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_BIT-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_BIT-1:0] out_data,
    output logic                mem_sw,
    output logic [ADDR_BIT-1:0] mem_waddr,
    output logic                mem_wen,
    output logic [DATA_BIT-1:0] mem_wdata,
    output logic [ADDR_BIT-1:0] mem_raddr,
    output logic                mem_ren,
    input  logic [DATA_BIT-1:0] mem_rdata,
    output logic                swap
);

    localparam logic [ADDR_BIT-1:0] LAST_ADDR = ADDR_BIT'(DEPTH - 1);

    logic [ADDR_BIT-1:0] wr_cnt;
    logic [ADDR_BIT-1:0] rd_cnt;
    logic                wr_done;
    logic                rd_done;
    logic                rd_inflight;
    logic                wr_fire;
    logic                pop;
    logic [1:0]          fifo_count;
    logic [2:0]          credit_used;

    // Write side: the RAM write port follows the producer handshake
    // combinationally.
    assign in_ready  = !wr_done;
    assign wr_fire   = in_valid && in_ready;
    assign mem_wen   = wr_fire;
    assign mem_waddr = wr_cnt;
    assign mem_wdata = in_data;

    // A swap commits as soon as the write bank is full and the read bank
    // has issued its last read.
    assign swap = wr_done && rd_done;

    // Read credit counts words stored plus the read in flight, minus any
    // word leaving this cycle. A read issues only while that total is
    // below two, so the two-entry FIFO can never overflow. With
    // out_ready held high, the FIFO still streams one word per cycle.
    assign pop         = out_valid && out_ready;
    assign credit_used = {1'b0, fifo_count} + {2'b00, rd_inflight} - {2'b00, pop};
    assign mem_ren     = !rd_done && (credit_used < 3'd2);
    assign mem_raddr   = rd_cnt;

    // Frame counters and bank select. After reset rd_done is set because
    // there is nothing to read, so the first complete frame swaps at once.
    // Counters stop at the last address instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_sw  <= 1'b0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            wr_done <= 1'b0;
            rd_done <= 1'b1;
        end else if (swap) begin
            mem_sw  <= ~mem_sw;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            wr_done <= 1'b0;
            rd_done <= 1'b0;
        end else begin
            if (wr_fire) begin
                if (wr_cnt == LAST_ADDR) begin
                    wr_done <= 1'b1;
                end else begin
                    wr_cnt <= wr_cnt + ADDR_BIT'(1);
                end
            end
            if (mem_ren) begin
                if (rd_cnt == LAST_ADDR) begin
                    rd_done <= 1'b1;
                end else begin
                    rd_cnt <= rd_cnt + ADDR_BIT'(1);
                end
            end
        end
    end

    // Track the read in flight; its data arrives next cycle. A read issued
    // just before a swap still lands, because the RAM registers its own
    // bank select alongside the address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_inflight <= 1'b0;
        end else begin
            rd_inflight <= mem_ren;
        end
    end

    mem_skid2 #(
        .DATA_BIT (DATA_BIT)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_inflight),
        .push_data (mem_rdata),
        .pop       (pop),
        .valid     (out_valid),
        .head      (out_data),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_mem_db_ctrl.sv
// Self-checking bench for mem_db_ctrl with DEPTH=4, DATA_BIT=8.
// Includes a behavioural two-bank RAM. The reference model expects every
// accepted input word to come out once, in acceptance order.
module tb_mem_db_ctrl;

    localparam int DATA_BIT = 8;
    localparam int DEPTH    = 4;
    localparam int ADDR_BIT = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [DATA_BIT-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_BIT-1:0] out_data;
    logic                mem_sw;
    logic [ADDR_BIT-1:0] mem_waddr;
    logic                mem_wen;
    logic [DATA_BIT-1:0] mem_wdata;
    logic [ADDR_BIT-1:0] mem_raddr;
    logic                mem_ren;
    logic [DATA_BIT-1:0] mem_rdata;
    logic                swap;

    always #5 clk = ~clk;

    mem_db_ctrl #(
        .DATA_BIT (DATA_BIT),
        .DEPTH    (DEPTH),
        .ADDR_BIT (ADDR_BIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .mem_sw    (mem_sw),
        .mem_waddr (mem_waddr),
        .mem_wen   (mem_wen),
        .mem_wdata (mem_wdata),
        .mem_raddr (mem_raddr),
        .mem_ren   (mem_ren),
        .mem_rdata (mem_rdata),
        .swap      (swap)
    );

    // Double-buffer RAM. The bank select is sampled with each access,
    // so data is read from the bank selected when the read was issued.
    logic [DATA_BIT-1:0] bank0 [DEPTH];
    logic [DATA_BIT-1:0] bank1 [DEPTH];

    always @(posedge clk) begin
        if (mem_wen) begin
            if (mem_sw) bank0[mem_waddr] <= mem_wdata;
            else        bank1[mem_waddr] <= mem_wdata;
        end
        if (mem_ren) begin
            mem_rdata <= mem_sw ? bank1[mem_raddr] : bank0[mem_raddr];
        end
    end

    int passed = 0;
    int total  = 0;

    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    int         in_cyc [$];
    int         got_cyc [$];
    int         cyc       = 0;
    int         reads     = 0;
    int         pops      = 0;
    int         max_occ   = 0;
    int         swap_cnt  = 0;
    bit         rand_ready = 1'b0;

    task automatic clear_model();
        exp_q.delete();
        got_q.delete();
        in_cyc.delete();
        got_cyc.delete();
        reads    = 0;
        pops     = 0;
        max_occ  = 0;
        swap_cnt = 0;
    endtask

    // One clock: sample the handshakes mid-cycle, then step past the edge.
    task automatic tick();
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (rst_n) begin
            if (reads - pops > max_occ) max_occ = reads - pops;
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                in_cyc.push_back(cyc);
            end
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                got_cyc.push_back(cyc);
                pops++;
            end
            if (mem_ren) reads++;
            if (swap) swap_cnt++;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int cycles);
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        rand_ready = 1'b0;
        out_ready  = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        clear_model();
    endtask

    task automatic push_word(input logic [7:0] d, output int stalls);
        bit acc;
        acc    = 1'b0;
        stalls = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 60 && !acc; i++) begin
            acc = in_ready;
            if (!acc) stalls++;
            tick();
        end
        in_valid = 1'b0;
        if (!acc) begin
            total++;
            $display("[TB] FAIL push_timeout word=%02h: stalled %0d cycles, required acceptance", d, stalls);
        end
    endtask

    task automatic drain(input int budget);
        for (int n = 0; n < budget && got_q.size() < exp_q.size(); n++) tick();
    endtask

    task automatic test_reset();
        apply_reset(3);
        total++; if (out_valid !== 1'b0) $display("[TB] FAIL rst_out_valid got %b want 0", out_valid); else passed++;
        total++; if (mem_sw !== 1'b0)    $display("[TB] FAIL rst_mem_sw got %b want 0", mem_sw); else passed++;
        total++; if (swap !== 1'b0)      $display("[TB] FAIL rst_swap got %b want 0", swap); else passed++;
        total++; if (mem_ren !== 1'b0)   $display("[TB] FAIL rst_mem_ren got %b want 0", mem_ren); else passed++;
        total++; if (mem_wen !== 1'b0)   $display("[TB] FAIL rst_mem_wen got %b want 0", mem_wen); else passed++;
        total++; if (in_ready !== 1'b1)  $display("[TB] FAIL rst_in_ready got %b want 1", in_ready); else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_single_frame();
        int st;
        logic [7:0] g;
        int c0, c3, lat;
        apply_reset(2);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_word(8'(8'h10 + i), st);
        drain(40);
        repeat (4) tick();
        total++; if (got_q.size() != 4) $display("[TB] FAIL single_count got %0d want 4", got_q.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            total++; if (g !== 8'(8'h10 + i)) $display("[TB] FAIL single_word%0d got %02h want %02h", i, g, 8'(8'h10 + i)); else passed++;
        end
        c0  = (got_cyc.size() > 0) ? got_cyc[0] : -100;
        c3  = (got_cyc.size() > 3) ? got_cyc[3] : -100;
        lat = (in_cyc.size() > 3) ? c0 - in_cyc[3] : -1;
        total++; if (c3 - c0 != 3) $display("[TB] FAIL single_gapless got span %0d want 3", c3 - c0); else passed++;
        // Last word accepted at edge E0; the swap commits at E1, the read
        // issues at E2 and the FIFO loads at E3. The first word is
        // therefore presented four cycles after the last-word handshake.
        total++; if (lat != 4) $display("[TB] FAIL single_latency got %0d want 4", lat); else passed++;
        total++; if (swap_cnt != 1) $display("[TB] FAIL single_swaps got %0d want 1", swap_cnt); else passed++;
        total++; if (mem_sw !== 1'b1) $display("[TB] FAIL single_mem_sw got %b want 1", mem_sw); else passed++;
    endtask

    task automatic test_back_to_back();
        int st;
        logic [7:0] d;
        logic [7:0] g;
        logic [7:0] sent [$];
        apply_reset(2);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int w = 0; w < 4; w++) begin
                d = 8'($urandom);
                push_word(d, st);
                sent.push_back(d);
                if (w == 0 && f > 0) begin
                    total++; if (st > 1) $display("[TB] FAIL b2b_stall_f%0d got %0d want <=1", f, st); else passed++;
                end
            end
        end
        drain(80);
        total++; if (got_q.size() != 12) $display("[TB] FAIL b2b_count got %0d want 12", got_q.size()); else passed++;
        for (int i = 0; i < 12; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            total++; if (g !== sent[i]) $display("[TB] FAIL b2b_word%0d got %02h want %02h", i, g, sent[i]); else passed++;
        end
    endtask

    task automatic test_backpressure();
        int st;
        logic [7:0] g;
        logic [7:0] w;
        apply_reset(2);
        rst_n     = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(8'(8'h10 + i), st);
        repeat (6) tick();
        total++; if (mem_ren !== 1'b0)   $display("[TB] FAIL bp_mem_ren got %b want 0", mem_ren); else passed++;
        total++; if (out_valid !== 1'b1) $display("[TB] FAIL bp_out_valid got %b want 1", out_valid); else passed++;
        total++; if (out_data !== 8'h10) $display("[TB] FAIL bp_out_data got %02h want 10", out_data); else passed++;
        total++; if (reads != 2)         $display("[TB] FAIL bp_reads got %0d want 2", reads); else passed++;
        for (int i = 0; i < 4; i++) push_word(8'(8'h20 + i), st);
        repeat (3) tick();
        total++; if (in_ready !== 1'b0)  $display("[TB] FAIL bp_in_ready got %b want 0", in_ready); else passed++;
        out_ready = 1'b1;
        drain(60);
        for (int i = 0; i < 8; i++) begin
            w = (i < 4) ? 8'(8'h10 + i) : 8'(8'h20 + i - 4);
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            total++; if (g !== w) $display("[TB] FAIL bp_word%0d got %02h want %02h", i, g, w); else passed++;
        end
    endtask

    task automatic test_random();
        int st;
        logic [7:0] d;
        logic [7:0] g;
        logic [7:0] sent [$];
        apply_reset(2);
        rst_n      = 1'b1;
        rand_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            d = 8'($urandom);
            push_word(d, st);
            sent.push_back(d);
        end
        drain(400);
        rand_ready = 1'b0;
        total++; if (got_q.size() != 16) $display("[TB] FAIL rand_count got %0d want 16", got_q.size()); else passed++;
        for (int i = 0; i < 16; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            total++; if (g !== sent[i]) $display("[TB] FAIL rand_word%0d got %02h want %02h", i, g, sent[i]); else passed++;
        end
        total++; if (max_occ > 2) $display("[TB] FAIL rand_occupancy got %0d want <=2", max_occ); else passed++;
    endtask

    task automatic test_mid_reset();
        int st;
        logic [7:0] g;
        apply_reset(2);
        rst_n     = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(8'(8'h30 + i), st);
        push_word(8'h40, st);
        push_word(8'h41, st);
        repeat (2) tick();
        total++; if (reads != 2) $display("[TB] FAIL mid_reads_before got %0d want 2", reads); else passed++;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) $display("[TB] FAIL mid_out_valid got %b want 0", out_valid); else passed++;
        total++; if (mem_sw !== 1'b0)    $display("[TB] FAIL mid_mem_sw got %b want 0", mem_sw); else passed++;
        rst_n = 1'b1;
        clear_model();
        total++; if (in_ready !== 1'b1)  $display("[TB] FAIL mid_in_ready got %b want 1", in_ready); else passed++;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_word(8'(8'hA0 + i), st);
        drain(40);
        repeat (3) tick();
        total++; if (got_q.size() != 4) $display("[TB] FAIL mid_count got %0d want 4", got_q.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            total++; if (g !== 8'(8'hA0 + i)) $display("[TB] FAIL mid_word%0d got %02h want %02h", i, g, 8'(8'hA0 + i)); else passed++;
        end
        total++; if (mem_sw !== 1'b1) $display("[TB] FAIL mid_mem_sw_after got %b want 1", mem_sw); else passed++;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
